// File: rtl/exp_truth_table_checker.sv
// exp_truth_table_checker
// Sweeps the four-input vector {A,B,C,D} from 0 to 15, holds each vector for a
// settle interval, then checks the returned F1/F2 against a golden truth table.
// Results report pass/fail, how many vectors failed, and the first failing vector.
module exp_truth_table_checker #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED      = 16'h551F
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    input  logic       F1_in,
    input  logic       F2_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic       fail_valid,
    output logic [3:0] first_fail_idx,
    output logic [1:0] first_fail_mask
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Last settle count before moving to the sample cycle.
    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state;
    logic [3:0] idx;
    logic [3:0] cnt;

    logic       exp_bit;
    logic       m1;
    logic       m2;
    logic       miss;
    logic [4:0] err_next;

    // The stimulus lines are the vector index itself, A as the MSB.
    assign {A, B, C, D} = idx;

    // Compare both responses with the golden bit of the current vector.
    assign exp_bit  = EXPECTED[idx];
    assign m1       = F1_in ^ exp_bit;
    assign m2       = F2_in ^ exp_bit;
    assign miss     = m1 | m2;
    assign err_next = err_count + 5'(miss);

    // Sweep control: start, settle, sample, advance or finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            idx             <= 4'd0;
            cnt             <= 4'd0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= 5'd0;
            fail_valid      <= 1'b0;
            first_fail_idx  <= 4'd0;
            first_fail_mask <= 2'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // Results hold in DONE until a new start is accepted.
                    if (start) begin
                        state           <= S_SETTLE;
                        idx             <= 4'd0;
                        cnt             <= 4'd0;
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        pass            <= 1'b0;
                        err_count       <= 5'd0;
                        fail_valid      <= 1'b0;
                        first_fail_idx  <= 4'd0;
                        first_fail_mask <= 2'd0;
                    end
                end
                S_SETTLE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (miss) begin
                        err_count <= err_next;
                    end
                    if (miss && !fail_valid) begin
                        fail_valid      <= 1'b1;
                        first_fail_idx  <= idx;
                        first_fail_mask <= {m2, m1};
                    end
                    if (idx == 4'hF) begin
                        // Index stays at 15 so A..D hold 4'hF while done.
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 5'd0);
                    end else begin
                        idx   <= idx + 4'd1;
                        cnt   <= 4'd0;
                        state <= S_SETTLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
